// File: rtl/bru_resolve_unit.sv
// Branch resolve stage: registers a resolved branch, detects mispredicts, drives ROB completion/flush,
// frontend redirect with post-redirect drain, predictor updates and saturating performance counters.
module bru_resolve_unit #(
    parameter int ROB_IDX_W    = 6,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_N_in,
    input  logic                 ext_flush_in,
    input  logic                 bru_valid_in,
    output logic                 bru_ready_out,
    input  logic                 bru_taken_in,
    input  logic [63:0]          bru_target_in,
    input  logic [63:0]          bru_pc_in,
    input  logic [ROB_IDX_W-1:0] bru_rob_idx_in,
    input  logic                 bru_pred_taken_in,
    input  logic [63:0]          bru_pred_target_in,
    output logic                 resolve_valid_out,
    output logic [ROB_IDX_W-1:0] resolve_rob_idx_out,
    output logic                 resolve_mispred_out,
    output logic                 flush_out,
    output logic [ROB_IDX_W-1:0] flush_rob_idx_out,
    output logic                 redirect_valid_out,
    input  logic                 redirect_ready_in,
    output logic [63:0]          redirect_pc_out,
    output logic                 bp_upd_valid_out,
    output logic [63:0]          bp_upd_pc_out,
    output logic                 bp_upd_taken_out,
    output logic [63:0]          bp_upd_target_out,
    output logic [CNT_W-1:0]     branch_cnt_out,
    output logic [CNT_W-1:0]     mispred_cnt_out
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REDIR = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic [63:0]          redirect_pc_q, redirect_pc_d;

    logic                 s_valid_q, s_valid_d;
    logic                 s_taken_q, s_taken_d;
    logic                 s_pred_taken_q, s_pred_taken_d;
    logic [63:0]          s_pc_q, s_pc_d;
    logic [63:0]          s_target_q, s_target_d;
    logic [63:0]          s_pred_target_q, s_pred_target_d;
    logic [ROB_IDX_W-1:0] s_rob_idx_q, s_rob_idx_d;

    logic [CNT_W-1:0]     branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]     mispred_cnt_q, mispred_cnt_d;

    logic [63:0]          s_pc_plus4;
    logic [63:0]          s_actual_next;
    logic [63:0]          s_pred_next;
    logic                 s_mispred;
    logic                 s_fire;
    logic                 accept;

    assign s_pc_plus4    = s_pc_q + 64'd4;
    assign s_actual_next = s_taken_q      ? s_target_q      : s_pc_plus4;
    assign s_pred_next   = s_pred_taken_q ? s_pred_target_q : s_pc_plus4;
    assign s_mispred     = (s_actual_next != s_pred_next);
    assign s_fire        = s_valid_q & ~ext_flush_in;

    // A branch behind a resolving mispredict is on the wrong path, so hold it off
    // rather than let it slip into the stage while the redirect is pending.
    assign bru_ready_out = (state_q == ST_IDLE) & ~(s_valid_q & s_mispred);
    assign accept        = bru_valid_in & bru_ready_out & ~ext_flush_in;

    // NOTE: every combinational output gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        redirect_pc_d = redirect_pc_q;
        if (ext_flush_in) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (s_fire && s_mispred) begin
                        state_d       = ST_REDIR;
                        redirect_pc_d = s_actual_next;
                    end
                end
                ST_REDIR: begin
                    if (redirect_ready_in) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == '0) state_d = ST_IDLE;
                    else               drain_d = drain_q - 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_valid_d       = accept;
        s_taken_d       = s_taken_q;
        s_pred_taken_d  = s_pred_taken_q;
        s_pc_d          = s_pc_q;
        s_target_d      = s_target_q;
        s_pred_target_d = s_pred_target_q;
        s_rob_idx_d     = s_rob_idx_q;
        if (accept) begin
            s_taken_d       = bru_taken_in;
            s_pred_taken_d  = bru_pred_taken_in;
            s_pc_d          = bru_pc_in;
            s_target_d      = bru_target_in;
            s_pred_target_d = bru_pred_target_in;
            s_rob_idx_d     = bru_rob_idx_in;
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (s_fire && (branch_cnt_q != '1))
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        if (s_fire && s_mispred && (mispred_cnt_q != '1))
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    // The stage payload is reset as well: result outputs are driven straight from it and must read 0 out of reset.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_q         <= ST_IDLE;
            drain_q         <= '0;
            redirect_pc_q   <= '0;
            s_valid_q       <= 1'b0;
            s_taken_q       <= 1'b0;
            s_pred_taken_q  <= 1'b0;
            s_pc_q          <= '0;
            s_target_q      <= '0;
            s_pred_target_q <= '0;
            s_rob_idx_q     <= '0;
            branch_cnt_q    <= '0;
            mispred_cnt_q   <= '0;
        end else begin
            state_q         <= state_d;
            drain_q         <= drain_d;
            redirect_pc_q   <= redirect_pc_d;
            s_valid_q       <= s_valid_d;
            s_taken_q       <= s_taken_d;
            s_pred_taken_q  <= s_pred_taken_d;
            s_pc_q          <= s_pc_d;
            s_target_q      <= s_target_d;
            s_pred_target_q <= s_pred_target_d;
            s_rob_idx_q     <= s_rob_idx_d;
            branch_cnt_q    <= branch_cnt_d;
            mispred_cnt_q   <= mispred_cnt_d;
        end
    end

    assign resolve_valid_out   = s_fire;
    assign resolve_rob_idx_out = s_rob_idx_q;
    assign resolve_mispred_out = s_fire & s_mispred;
    assign flush_out           = s_fire & s_mispred & (state_q == ST_IDLE);
    assign flush_rob_idx_out   = s_rob_idx_q;
    assign redirect_valid_out  = (state_q == ST_REDIR);
    assign redirect_pc_out     = redirect_pc_q;
    assign bp_upd_valid_out    = s_fire;
    assign bp_upd_pc_out       = s_pc_q;
    assign bp_upd_taken_out    = s_taken_q;
    assign bp_upd_target_out   = s_target_q;
    assign branch_cnt_out      = branch_cnt_q;
    assign mispred_cnt_out     = mispred_cnt_q;

endmodule
